mem_read_d_sched: RTL and testbench

Job-level sequencer for the D-operand address generator of the systolic matmul datapath.
- Accepts one job descriptor (M1, M3) over a valid/ready handshake and validates it.
- Pulses a synchronous reset into the generator, then streams exactly M1dN1*N1*M3 valid_D beats, honouring downstream stall.
- Waits a fixed drain latency, then reports done.
- Sits between the layer control FSM and the D-side address generator / D buffer.

---
 rtl/mm_pkg.sv | 25 ++
 rtl/mem_read_d_sched_cnt.sv | 29 ++
 rtl/mem_read_d_sched.sv | 166 ++++++++++++++++
 tb/tb_mem_read_d_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the D-operand job sequencer.
package mm_pkg;

  // Job-level sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STREAM,
    DRAIN,
    DONE
  } sched_state_t;

  // Shift amount that divides a row count by N1 (N1 is a power of two).
  function automatic int n1_shift(input int n1);
    return $clog2(n1);
  endfunction

  // True when m has no bits set below log2(n1), i.e. m is a multiple of n1.
  function automatic logic is_mult_of_n1(input logic [31:0] m, input int n1);
    logic [31:0] mask;
    mask = 32'(n1) - 32'd1;
    return (m & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_read_d_sched_cnt.sv
// Loadable up-counter with terminal-count compare. Used for both the issued
// beat count and the drain latency count.
module mem_read_d_sched_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         at_limit,
  output logic         last
);

  logic [W-1:0] count;

  // Count up while enabled; clear takes priority so a new job starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count == limit);
  assign last     = ((count + W'(1)) == limit);

endmodule

// File: rtl/mem_read_d_sched.sv
// Job-level sequencer for the D-operand address generator: accepts and
// validates a (M1, M3) descriptor, pulses the generator reset, streams
// M1dN1*N1*M3 valid_D beats under stall, drains, then reports done.
// Optional performance counters: define MEM_READ_D_SCHED_PERF_EN.
module mem_read_d_sched
  import mm_pkg::*;
#(
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int DRAIN_CYC    = 4,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [MATRIXSIZE_W-1:0] cfg_M1,
  input  logic [MATRIXSIZE_W-1:0] cfg_M3,
  input  logic                    stall,
  output logic                    gen_rst,
  output logic                    valid_D,
  output logic [MATRIXSIZE_W-1:0] M3,
  output logic [MATRIXSIZE_W-1:0] M1dN1,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef MEM_READ_D_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]        perf_stall_cyc,
  output logic [CNT_W-1:0]        perf_job_cyc
`endif
);

  localparam int SHIFT = n1_shift(N1);

  // N2 only travels alongside the job; nothing here depends on it.
  if (N1 < 2 || N2 < 1) begin : g_param_out_of_range
  end

  sched_state_t state, state_next;

  logic [CNT_W-1:0]          total;
  logic [2*MATRIXSIZE_W-1:0] job_prod;
  logic                      cfg_take;
  logic                      cfg_ok;
  logic                      iss_clr, iss_at_limit, iss_last;
  logic                      drn_clr, drn_at_limit, drn_last;

  assign cfg_take = cfg_valid && (state == IDLE);
  assign cfg_ok   = (cfg_M1 != '0) && (cfg_M3 != '0) &&
                    is_mult_of_n1(32'(cfg_M1), N1);
  // For an accepted job M1dN1*N1 equals cfg_M1, so the beat total is M1*M3.
  assign job_prod = (2*MATRIXSIZE_W)'(cfg_M1) * (2*MATRIXSIZE_W)'(cfg_M3);

  // State register; reset aborts any job straight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    gen_rst    = 1'b0;
    valid_D    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    iss_clr    = 1'b0;
    drn_clr    = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_ok) state_next = INIT;
      end
      INIT: begin
        gen_rst    = 1'b1;
        busy       = 1'b1;
        iss_clr    = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        drn_clr = 1'b1;
        valid_D = !stall && !iss_at_limit;
        // A zero total (only possible through truncation) must not hang here.
        if ((valid_D && iss_last) || iss_at_limit) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drn_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the job descriptor on acceptance and flag rejected descriptors.
  always_ff @(posedge clk) begin
    if (rst) begin
      M3    <= '0;
      M1dN1 <= '0;
      total <= '0;
      err   <= 1'b0;
    end else begin
      err <= cfg_take && !cfg_ok;
      if (cfg_take && cfg_ok) begin
        M3    <= cfg_M3;
        M1dN1 <= cfg_M1 >> SHIFT;
        total <= CNT_W'(job_prod);
      end
    end
  end

  mem_read_d_sched_cnt #(.W(CNT_W)) u_issued (
    .clk      (clk),
    .rst      (rst),
    .clr      (iss_clr),
    .en       (valid_D),
    .limit    (total),
    .at_limit (iss_at_limit),
    .last     (iss_last)
  );

  mem_read_d_sched_cnt #(.W(CNT_W)) u_drain (
    .clk      (clk),
    .rst      (rst),
    .clr      (drn_clr),
    .en       (state == DRAIN),
    .limit    (CNT_W'(DRAIN_CYC)),
    .at_limit (drn_at_limit),
    .last     (drn_last)
  );

`ifdef MEM_READ_D_SCHED_PERF_EN
  // Job and stall cycle counters: restart at INIT, hold from DONE onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_job_cyc   <= '0;
    end else begin
      case (state)
        INIT: begin
          perf_stall_cyc <= '0;
          perf_job_cyc   <= CNT_W'(1);
        end
        STREAM: begin
          perf_job_cyc <= perf_job_cyc + CNT_W'(1);
          if (stall && !iss_at_limit) perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
        end
        DRAIN, DONE: perf_job_cyc <= perf_job_cyc + CNT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_d_sched.sv
// Self-checking bench for mem_read_d_sched: scoreboard of expected jobs,
// one task per scenario. Inputs change on the falling edge, outputs are
// sampled 1ns later.
module tb_mem_read_d_sched;

  localparam int N1        = 4;
  localparam int N2        = 4;
  localparam int MW        = 16;
  localparam int DRAIN_CYC = 4;
  localparam int CNT_W     = 32;
  localparam int LIMIT     = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [MW-1:0] cfg_M1 = '0;
  logic [MW-1:0] cfg_M3 = '0;
  logic          stall = 1'b0;
  logic          gen_rst, valid_D, busy, done, err;
  logic [MW-1:0] M3, M1dN1;
`ifdef MEM_READ_D_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_stall_cyc, perf_job_cyc;
`endif

  mem_read_d_sched #(
    .N1(N1), .N2(N2), .MATRIXSIZE_W(MW), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_M1(cfg_M1), .cfg_M3(cfg_M3), .stall(stall), .gen_rst(gen_rst),
    .valid_D(valid_D), .M3(M3), .M1dN1(M1dN1), .busy(busy), .done(done),
    .err(err)
`ifdef MEM_READ_D_SCHED_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_job_cyc(perf_job_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          beats;
    logic [MW-1:0] m1dn1;
    logic [MW-1:0] m3;
  } exp_t;

  typedef struct {
    int          beats;
    int          viol;
    int          gaps;
    int          extra_gen_rst;
    int          busy_low;
    int          ready_high;
    int          last_k;
    int          done_k;
    bit          done_seen;
    logic        init_gen_rst;
    logic        init_busy;
    logic [MW-1:0] m1dn1;
    logic [MW-1:0] m3;
  } obs_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Present a descriptor for one cycle in IDLE and record the expected job.
  task automatic drive_accept(input logic [MW-1:0] m1, input logic [MW-1:0] m3,
                              output logic ready_seen);
    exp_t e;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_M1    = m1;
    cfg_M3    = m3;
    #1;
    ready_seen = cfg_ready;
    e.beats = int'(m1) * int'(m3);
    e.m1dn1 = m1 / MW'(N1);
    e.m3    = m3;
    exp_q.push_back(e);
  endtask

  // Step through INIT, STREAM, DRAIN and DONE, recording what the DUT did.
  // Stall is high on stream cycles lo..hi and optionally once on the final beat.
  task automatic observe(input int lo, input int hi, input bit stall_last,
                         input bit hold, input logic [MW-1:0] nm1,
                         input logic [MW-1:0] nm3, output obs_t o);
    int  total;
    bit  last_stalled;
    bit  s;
    o = '{default: 0};
    total = (exp_q.size() != 0) ? exp_q[0].beats : 0;
    last_stalled = 1'b0;
    @(negedge clk);
    cfg_valid = hold;
    cfg_M1    = nm1;
    cfg_M3    = nm3;
    #1;
    o.init_gen_rst = gen_rst;
    o.init_busy    = busy;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      s = (k >= lo) && (k <= hi);
      if (stall_last && (o.beats == total - 1) && !last_stalled) begin
        s = 1'b1;
        last_stalled = 1'b1;
      end
      stall = s;
      #1;
      if (gen_rst)   o.extra_gen_rst++;
      if (!busy)     o.busy_low++;
      if (cfg_ready) o.ready_high++;
      if (valid_D) begin
        o.beats++;
        o.last_k = k;
        if (s) o.viol++;
      end else if (!s && o.beats < total) begin
        o.gaps++;
      end
      if (done) begin
        o.done_seen = 1'b1;
        o.done_k    = k;
        o.m1dn1     = M1dN1;
        o.m3        = M3;
        break;
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_checks++;
    if ({gen_rst, valid_D, busy, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {gen_rst, valid_D, busy, done, err});
    end
    n_checks++;
    if ({M3, M1dN1} !== '0) begin n_fail++; $display("FAIL reset_regs got %h want 0", {M3, M1dN1}); end
    rst = 1'b0;
    $display("reset: cfg_ready=%b busy=%b valid_D=%b", cfg_ready, busy, valid_D);
  endtask

  // Shared comparison block body, written out per scenario.
  task automatic test_single();
    logic rdy;
    obs_t o;
    exp_t e;
    drive_accept(16'd8, 16'd3, rdy);
    observe(1, 0, 1'b0, 1'b0, 16'd0, 16'd0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", rdy); end
    n_checks++;
    if (o.init_gen_rst !== 1'b1) begin n_fail++; $display("FAIL single_gen_rst got %b want 1", o.init_gen_rst); end
    n_checks++;
    if (!o.done_seen) begin n_fail++; $display("FAIL single_done_timeout got 0 want 1"); end
    n_checks++;
    if (o.beats != e.beats || o.gaps != 0) begin
      n_fail++; $display("FAIL single_beats got %0d gaps %0d want %0d gaps 0", o.beats, o.gaps, e.beats);
    end
    n_checks++;
    if (o.done_k - o.last_k != DRAIN_CYC + 1) begin
      n_fail++; $display("FAIL single_drain got %0d want %0d", o.done_k - o.last_k, DRAIN_CYC + 1);
    end
    n_checks++;
    if (o.m1dn1 !== e.m1dn1 || o.m3 !== e.m3) begin
      n_fail++; $display("FAIL single_regs got %0d/%0d want %0d/%0d", o.m1dn1, o.m3, e.m1dn1, e.m3);
    end
    n_checks++;
    if (o.busy_low != 0 || o.ready_high != 0 || o.extra_gen_rst != 0) begin
      n_fail++; $display("FAIL single_flags got busy_low %0d ready_high %0d gen_rst %0d want 0",
                         o.busy_low, o.ready_high, o.extra_gen_rst);
    end
    $display("single: beats=%0d last=%0d done=%0d M1dN1=%0d", o.beats, o.last_k, o.done_k, o.m1dn1);
  endtask

  task automatic test_stall();
    logic rdy;
    obs_t o;
    exp_t e;
    drive_accept(16'd8, 16'd3, rdy);
    observe(5, 7, 1'b1, 1'b0, 16'd0, 16'd0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o.beats != e.beats || o.viol != 0) begin
      n_fail++; $display("FAIL stall_beats got %0d viol %0d want %0d viol 0", o.beats, o.viol, e.beats);
    end
    n_checks++;
    if (o.last_k != e.beats + 4) begin n_fail++; $display("FAIL stall_last_beat got %0d want %0d", o.last_k, e.beats + 4); end
    n_checks++;
    if (!o.done_seen || o.done_k != e.beats + 4 + DRAIN_CYC + 1) begin
      n_fail++; $display("FAIL stall_done got %0d want %0d", o.done_k, e.beats + 4 + DRAIN_CYC + 1);
    end
    @(negedge clk);
    #1;
`ifdef MEM_READ_D_SCHED_PERF_EN
    n_checks++;
    if (perf_stall_cyc !== 32'd4) begin n_fail++; $display("FAIL perf_stall got %0d want 4", perf_stall_cyc); end
    n_checks++;
    if (perf_job_cyc !== 32'(1 + 28 + DRAIN_CYC + 1)) begin
      n_fail++; $display("FAIL perf_job got %0d want %0d", perf_job_cyc, 1 + 28 + DRAIN_CYC + 1);
    end
`endif
    $display("stall: beats=%0d last=%0d done=%0d", o.beats, o.last_k, o.done_k);
  endtask

  task automatic test_reject();
    logic [MW-1:0] bad_m1 [3];
    logic [MW-1:0] bad_m3 [3];
    bad_m1 = '{16'd6, 16'd0, 16'd8};
    bad_m3 = '{16'd3, 16'd3, 16'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_M1    = bad_m1[i];
      cfg_M3    = bad_m3[i];
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reject_ready[%0d] got %b want 1", i, cfg_ready); end
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if ({err, gen_rst, busy, cfg_ready} !== 4'b1001) begin
        n_fail++; $display("FAIL reject_pulse[%0d] got %b want 1001", i, {err, gen_rst, busy, cfg_ready});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({err, gen_rst, busy} !== 3'b000) begin
        n_fail++; $display("FAIL reject_after[%0d] got %b want 000", i, {err, gen_rst, busy});
      end
      $display("reject: M1=%0d M3=%0d", bad_m1[i], bad_m3[i]);
    end
  endtask

  task automatic test_reset_mid_job();
    logic rdy;
    obs_t o;
    exp_t e;
    int   beats;
    drive_accept(16'd8, 16'd3, rdy);
    @(negedge clk);
    cfg_valid = 1'b0;
    beats = 0;
    for (int k = 0; k < LIMIT && beats < 10; k++) begin
      @(negedge clk);
      #1;
      if (valid_D) beats++;
    end
    n_checks++;
    if (beats != 10) begin n_fail++; $display("FAIL abort_reach got %0d want 10", beats); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({valid_D, busy, cfg_ready, gen_rst} !== 4'b0010) begin
      n_fail++; $display("FAIL abort_idle got %b want 0010", {valid_D, busy, cfg_ready, gen_rst});
    end
    void'(exp_q.pop_front());
    drive_accept(16'd8, 16'd3, rdy);
    observe(1, 0, 1'b0, 1'b0, 16'd0, 16'd0, o);
    e = exp_q.pop_front();
    n_checks++;
    if (o.beats != e.beats || !o.done_seen) begin
      n_fail++; $display("FAIL abort_rerun got %0d done %0d want %0d done 1", o.beats, o.done_seen, e.beats);
    end
    $display("abort: rerun beats=%0d", o.beats);
  endtask

  task automatic test_back_to_back();
    logic rdy_a, rdy_b;
    obs_t oa, ob;
    exp_t ea, eb;
    drive_accept(16'd4, 16'd1, rdy_a);
    observe(1, 0, 1'b0, 1'b1, 16'd16, 16'd2, oa);
    ea = exp_q.pop_front();
    drive_accept(16'd16, 16'd2, rdy_b);
    observe(1, 0, 1'b0, 1'b0, 16'd0, 16'd0, ob);
    eb = exp_q.pop_front();
    n_checks++;
    if (oa.beats != ea.beats || oa.extra_gen_rst != 0 || oa.ready_high != 0) begin
      n_fail++; $display("FAIL b2b_first got %0d gen_rst %0d ready %0d want %0d 0 0",
                         oa.beats, oa.extra_gen_rst, oa.ready_high, ea.beats);
    end
    n_checks++;
    if (rdy_b !== 1'b1 || ob.init_gen_rst !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got ready %b gen_rst %b want 1 1", rdy_b, ob.init_gen_rst);
    end
    n_checks++;
    if (ob.beats != eb.beats || ob.gaps != 0 || !ob.done_seen) begin
      n_fail++; $display("FAIL b2b_second got %0d gaps %0d want %0d gaps 0", ob.beats, ob.gaps, eb.beats);
    end
    n_checks++;
    if (ob.m1dn1 !== eb.m1dn1 || ob.m3 !== eb.m3) begin
      n_fail++; $display("FAIL b2b_regs got %0d/%0d want %0d/%0d", ob.m1dn1, ob.m3, eb.m1dn1, eb.m3);
    end
    $display("b2b: first=%0d second=%0d", oa.beats, ob.beats);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_reject();
    test_reset_mid_job();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
